// File: rtl/pad_rst_pkg.sv
// Shared types and limits for the pad-ring reset sequencer (pad_rst_seq).
// The SOFT encoding is reserved here even when KMIE_SOFT_RST_EN is not defined.
package pad_rst_pkg;

  typedef enum logic [2:0] {
    ST_HOLD  = 3'd0,
    ST_PADS  = 3'd1,
    ST_CLKEN = 3'd2,
    ST_RUN   = 3'd3,
    ST_SOFT  = 3'd4
  } seq_state_e;

  localparam int MIN_SYNC_STAGES     = 2;
  localparam int MIN_DEBOUNCE_CYCLES = 1;
  localparam int MIN_STAGE_GAP       = 1;

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchronizer with asynchronous reset to a selectable value.
// Used for both the reset de-assertion path and the clock-good status path.
module sync_ff
  import pad_rst_pkg::*;
#(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain_q;
  logic [STAGES-1:0] chain_d;

  if (STAGES < MIN_SYNC_STAGES) begin : g_bad_stages
    $error("sync_ff: STAGES must be at least 2");
  end

  always_comb begin
    chain_d = {chain_q[STAGES-2:0], d};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain_q <= {STAGES{RST_VAL}};
    end else begin
      chain_q <= chain_d;
    end
  end

  assign q = chain_q[STAGES-1];

endmodule

// File: rtl/pad_rst_seq.sv
// Pad-ring power-up sequencer: releases pad OE, then core clock enable, then core reset.
// Define KMIE_SOFT_RST_EN to add the soft_rst_req port and the SOFT core-reset state.
module pad_rst_seq
  import pad_rst_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int STAGE_GAP       = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clk_ok,
`ifdef KMIE_SOFT_RST_EN
  input  logic       soft_rst_req,
`endif
  output logic       pad_oe_en,
  output logic       core_clk_en,
  output logic       core_rst,
  output logic       rst_done,
  output logic [2:0] seq_state
);

  localparam int CNT_MAX = (DEBOUNCE_CYCLES > STAGE_GAP) ? DEBOUNCE_CYCLES : STAGE_GAP;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(STAGE_GAP - 1);

  if (SYNC_STAGES < MIN_SYNC_STAGES) begin : g_bad_sync
    $error("pad_rst_seq: SYNC_STAGES must be at least 2");
  end
  if (DEBOUNCE_CYCLES < MIN_DEBOUNCE_CYCLES) begin : g_bad_deb
    $error("pad_rst_seq: DEBOUNCE_CYCLES must be at least 1");
  end
  if (STAGE_GAP < MIN_STAGE_GAP) begin : g_bad_gap
    $error("pad_rst_seq: STAGE_GAP must be at least 1");
  end

  logic rst_s;
  logic ok_s;
  logic soft_req;

  seq_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pad_oe_q, pad_oe_d;
  logic             clk_en_q, clk_en_d;
  logic             core_rst_q, core_rst_d;
  logic             rst_done_q, rst_done_d;

  // Reset release: chain shifts in 0 and is forced to 1 while rst is high.
  sync_ff #(
    .STAGES  (SYNC_STAGES),
    .RST_VAL (1'b1)
  ) u_rst_sync (
    .clk (clk),
    .rst (rst),
    .d   (1'b0),
    .q   (rst_s)
  );

  sync_ff #(
    .STAGES  (SYNC_STAGES),
    .RST_VAL (1'b0)
  ) u_ok_sync (
    .clk (clk),
    .rst (rst),
    .d   (clk_ok),
    .q   (ok_s)
  );

`ifdef KMIE_SOFT_RST_EN
  assign soft_req = soft_rst_req;
`else
  assign soft_req = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;

    // Losing clock-good outranks every other transition outside HOLD.
    if (state_q != ST_HOLD && !ok_s) begin
      state_d = ST_HOLD;
    end else begin
      case (state_q)
        ST_HOLD: begin
          if (rst_s || !ok_s) begin
            cnt_d = '0;
          end else if (cnt_q == DEB_LAST) begin
            state_d = ST_PADS;
          end
        end
        ST_PADS: begin
          if (cnt_q == GAP_LAST) state_d = ST_CLKEN;
        end
        ST_CLKEN: begin
          if (cnt_q == GAP_LAST) state_d = ST_RUN;
        end
        ST_RUN: begin
          if (soft_req) state_d = ST_SOFT;
        end
`ifdef KMIE_SOFT_RST_EN
        ST_SOFT: begin
          if (cnt_q == GAP_LAST) state_d = ST_RUN;
        end
`endif
        default: state_d = ST_HOLD;
      endcase
    end

    if (state_d != state_q) cnt_d = '0;

    // Outputs are decoded from the next state so they register with it.
    pad_oe_d   = (state_d != ST_HOLD);
    clk_en_d   = (state_d == ST_CLKEN) || (state_d == ST_RUN) || (state_d == ST_SOFT);
    core_rst_d = (state_d != ST_RUN);
    rst_done_d = (state_d == ST_RUN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_HOLD;
      cnt_q      <= '0;
      pad_oe_q   <= 1'b0;
      clk_en_q   <= 1'b0;
      core_rst_q <= 1'b1;
      rst_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pad_oe_q   <= pad_oe_d;
      clk_en_q   <= clk_en_d;
      core_rst_q <= core_rst_d;
      rst_done_q <= rst_done_d;
    end
  end

  assign pad_oe_en   = pad_oe_q;
  assign core_clk_en = clk_en_q;
  assign core_rst    = core_rst_q;
  assign rst_done    = rst_done_q;
  assign seq_state   = state_q;

endmodule

// File: tb/tb_pad_rst_seq.sv
// Directed bench for pad_rst_seq at default parameters; soft-reset cases need KMIE_SOFT_RST_EN.
module tb_pad_rst_seq;

  // {pad_oe_en, core_clk_en, core_rst, rst_done, seq_state}
  localparam logic [6:0] O_HOLD  = 7'b0010_000;
  localparam logic [6:0] O_PADS  = 7'b1010_001;
  localparam logic [6:0] O_CLKEN = 7'b1110_010;
  localparam logic [6:0] O_RUN   = 7'b1101_011;
  localparam logic [6:0] O_SOFT  = 7'b1110_100;

  typedef struct {
    int         at_edge;
    logic       ok;
    logic [6:0] exp;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       clk_ok;
`ifdef KMIE_SOFT_RST_EN
  logic       soft_rst_req;
`endif
  logic       pad_oe_en;
  logic       core_clk_en;
  logic       core_rst;
  logic       rst_done;
  logic [2:0] seq_state;
  logic [6:0] outv;

  int n_cmp = 0;
  int n_bad = 0;
  int edge_n = 0;
  vec_t vecs[16];

  pad_rst_seq dut (
    .clk          (clk),
    .rst          (rst),
    .clk_ok       (clk_ok),
`ifdef KMIE_SOFT_RST_EN
    .soft_rst_req (soft_rst_req),
`endif
    .pad_oe_en    (pad_oe_en),
    .core_clk_en  (core_clk_en),
    .core_rst     (core_rst),
    .rst_done     (rst_done),
    .seq_state    (seq_state)
  );

  always #5 clk = ~clk;

  assign outv = {pad_oe_en, core_clk_en, core_rst, rst_done, seq_state};

  task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @edge %0d: got %b required %b", name, edge_n, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    edge_n++;
    #1;
  endtask

  task automatic run_to(input int k);
    while (edge_n < k) tick();
  endtask

  // Assert rst for a cycle, then drop it mid-cycle; the next posedge is edge 1.
  task automatic restart();
    rst    = 1'b1;
    clk_ok = 1'b1;
`ifdef KMIE_SOFT_RST_EN
    soft_rst_req = 1'b0;
`endif
    @(posedge clk);
    #4;
    rst    = 1'b0;
    edge_n = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{at_edge: 2,  ok: 1'b1, exp: O_HOLD};
    vecs[1]  = '{at_edge: 17, ok: 1'b1, exp: O_HOLD};
    vecs[2]  = '{at_edge: 18, ok: 1'b1, exp: O_PADS};
    vecs[3]  = '{at_edge: 25, ok: 1'b1, exp: O_PADS};
    vecs[4]  = '{at_edge: 26, ok: 1'b1, exp: O_CLKEN};
    vecs[5]  = '{at_edge: 33, ok: 1'b1, exp: O_CLKEN};
    vecs[6]  = '{at_edge: 34, ok: 1'b1, exp: O_RUN};
    vecs[7]  = '{at_edge: 36, ok: 1'b1, exp: O_RUN};
    vecs[8]  = '{at_edge: 38, ok: 1'b0, exp: O_RUN};
    vecs[9]  = '{at_edge: 39, ok: 1'b0, exp: O_HOLD};
    vecs[10] = '{at_edge: 40, ok: 1'b1, exp: O_HOLD};
    vecs[11] = '{at_edge: 56, ok: 1'b1, exp: O_HOLD};
    vecs[12] = '{at_edge: 57, ok: 1'b1, exp: O_PADS};
    vecs[13] = '{at_edge: 65, ok: 1'b1, exp: O_CLKEN};
    vecs[14] = '{at_edge: 72, ok: 1'b1, exp: O_CLKEN};
    vecs[15] = '{at_edge: 73, ok: 1'b1, exp: O_RUN};

    rst    = 1'b1;
    clk_ok = 1'b1;
`ifdef KMIE_SOFT_RST_EN
    soft_rst_req = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    check("reset_values", outv, O_HOLD);

    // Nominal release, clk_ok drop in RUN, and full re-run after clk_ok returns.
    restart();
    for (int i = 0; i < 16; i++) begin
      clk_ok = vecs[i].ok;
      run_to(vecs[i].at_edge);
      check($sformatf("seq_vec%0d", i), outv, vecs[i].exp);
    end

    // One-cycle clk_ok glitch seen by the HOLD counter at edge 10.
    restart();
    run_to(7);
    clk_ok = 1'b0;
    run_to(8);
    clk_ok = 1'b1;
    run_to(18);
    check("glitch_no_release_18", outv, O_HOLD);
    run_to(25);
    check("glitch_hold_25", outv, O_HOLD);
    run_to(26);
    check("glitch_pads_26", outv, O_PADS);

    // Asynchronous rst in PADS, mid-cycle.
    restart();
    run_to(22);
    check("pre_async_pads", outv, O_PADS);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_no_edge", outv, O_HOLD);
    @(posedge clk);
    #1;
    check("rst_held", outv, O_HOLD);

`ifdef KMIE_SOFT_RST_EN
    // Soft request in CLKEN is ignored.
    restart();
    run_to(29);
    soft_rst_req = 1'b1;
    run_to(30);
    soft_rst_req = 1'b0;
    check("soft_in_clken_ignored", outv, O_CLKEN);
    run_to(33);
    check("soft_clken_33", outv, O_CLKEN);
    run_to(34);
    check("soft_run_34", outv, O_RUN);

    // Soft request in RUN: 8 cycles of core_rst with gates held open.
    run_to(36);
    soft_rst_req = 1'b1;
    run_to(37);
    soft_rst_req = 1'b0;
    check("soft_enter_37", outv, O_SOFT);
    begin
      int hi_cnt;
      logic gates_ok;
      hi_cnt   = 1;
      gates_ok = pad_oe_en & core_clk_en;
      while (edge_n < 45) begin
        tick();
        if (core_rst) hi_cnt++;
        gates_ok &= pad_oe_en & core_clk_en;
      end
      check("soft_core_rst_cycles", 7'(hi_cnt), 7'd8);
      check("soft_gates_open", {6'd0, gates_ok}, 7'd1);
    end
    check("soft_back_run_45", outv, O_RUN);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
